// File: rtl/ysyx_22040237_lsu.sv
// ============================================================================
// ysyx_22040237_lsu
// ----------------------------------------------------------------------------
// Multi-cycle load/store unit for the ysyx_22040237 core. It takes one decoded
// load/store at a time, issues exactly one request on the data-memory port,
// waits for that request's response and hands a single completion pulse to
// writeback. Loads return a sign- or zero-extended result; stores return a
// completion with no register write.
//
// FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE (IDLE -> DONE for a misaligned
// access when the optional check is built in).
//
// Handshake: a memory request transfers in the cycle where mem_req_valid_o
// and mem_req_ready_i are both 1. mem_req_valid_o only rises in REQ and all
// mem_req_* outputs stay constant until that transfer. mem_resp_valid_i is
// only honoured in WAIT. lsu_ready_o is 1 only in IDLE, and an upstream access
// is taken when lsu_valid_i and lsu_ready_o are 1 with load_i or store_i set.
// There is no writeback backpressure: wb_valid_o is a one-cycle pulse.
//
// Configuration macro: YSYX_22040237_LSU_MISALIGN_EN
//   defined   : misaligned half/word/double accesses skip the memory request
//               and complete with misalign_o=1.
//   undefined : misalign_o is tied to 0; every access is issued, bytes beyond
//               lane 7 are dropped (store strobes truncated, missing load
//               bytes read as 0 before extension).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   lsu_valid_i/ready_o    upstream access handshake
//   load_i, store_i        access type (never both 1)
//   usign_i, size_i        zero-extend flag, size 00=B 01=H 10=W 11=D
//   base_i, offset_i       address operands (sum modulo 2^ADDR_W)
//   wdata_i, rd_idx_i      store data, destination register
//   mem_req_*              request channel to data memory
//   mem_resp_*             response channel (read data / write ack)
//   wb_*                   writeback completion
//   misalign_o             completion was a misaligned access
// ============================================================================
module ysyx_22040237_lsu #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic              load_i,
    input  logic              store_i,
    input  logic              usign_i,
    input  logic [1:0]        size_i,
    input  logic [63:0]       base_i,
    input  logic [63:0]       offset_i,
    input  logic [63:0]       wdata_i,
    input  logic [4:0]        rd_idx_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_wen_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [63:0]       mem_req_wdata_o,
    output logic [7:0]        mem_req_wstrb_o,
    input  logic              mem_resp_valid_i,
    input  logic [63:0]       mem_resp_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_wen_o,
    output logic [4:0]        wb_rd_idx_o,
    output logic [63:0]       wb_data_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_usign;
    logic              r_store;
    logic [63:0]       r_wdata;
    logic [4:0]        r_rd_idx;
    logic [63:0]       r_rdata;

    logic [63:0]       w_sum;
    logic [ADDR_W-1:0] w_addr_new;
    logic              w_go;
    logic              w_mis_new;
    logic [2:0]        w_off;
    logic [7:0]        w_mask;
    logic [15:0]       w_strb_wide;
    logic [63:0]       w_wdata_lane;
    logic [63:0]       w_sh;
    logic [63:0]       w_ext;

    // Address wraps modulo 2^ADDR_W; upper sum bits are simply not kept.
    assign w_sum      = base_i + offset_i;
    assign w_addr_new = w_sum[ADDR_W-1:0];
    assign w_go       = lsu_valid_i & (load_i | store_i);
    assign w_off      = r_addr[2:0];

`ifdef YSYX_22040237_LSU_MISALIGN_EN
    logic r_misalign;

    always_comb begin
        w_mis_new = 1'b0;
        case (size_i)
            2'b01:   w_mis_new = w_sum[0];
            2'b10:   w_mis_new = (w_sum[1:0] != 2'b00);
            2'b11:   w_mis_new = (w_sum[2:0] != 3'b000);
            default: w_mis_new = 1'b0;
        endcase
    end
`else
    assign w_mis_new = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and latched access fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_usign  <= 1'b0;
            r_store  <= 1'b0;
            r_wdata  <= 64'd0;
            r_rd_idx <= 5'd0;
            r_rdata  <= 64'd0;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_go) begin
                r_addr   <= w_addr_new;
                r_size   <= size_i;
                r_usign  <= usign_i;
                r_store  <= store_i;
                r_wdata  <= wdata_i;
                r_rd_idx <= rd_idx_i;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
                r_misalign <= w_mis_new;
`endif
            end
            if (r_state == S_WAIT && mem_resp_valid_i) begin
                r_rdata <= mem_resp_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_next = w_mis_new ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lane alignment and load extension
    // ------------------------------------------------------------------
    always_comb begin
        w_mask = 8'h01;
        case (r_size)
            2'b00:   w_mask = 8'h01;
            2'b01:   w_mask = 8'h03;
            2'b10:   w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    // Shifting in a 16-bit field and keeping the low byte drops strobes that
    // would fall beyond lane 7.
    assign w_strb_wide  = {8'h00, w_mask} << w_off;
    assign w_wdata_lane = r_wdata << {w_off, 3'b000};
    assign w_sh         = r_rdata >> {w_off, 3'b000};

    always_comb begin
        w_ext = 64'd0;
        case (r_size)
            2'b00:   w_ext = r_usign ? {56'd0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
            2'b01:   w_ext = r_usign ? {48'd0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
            2'b10:   w_ext = r_usign ? {32'd0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
            default: w_ext = w_sh;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: everything is decoded from the current state so that idle
    // and reset cycles present all-zero buses.
    // ------------------------------------------------------------------
    always_comb begin
        lsu_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_wen_o   = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = 64'd0;
        mem_req_wstrb_o = 8'h00;
        wb_valid_o      = 1'b0;
        wb_wen_o        = 1'b0;
        wb_rd_idx_o     = 5'd0;
        wb_data_o       = 64'd0;
        misalign_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                lsu_ready_o = 1'b1;
            end
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_wen_o   = r_store;
                mem_req_addr_o  = r_addr;
                if (r_store) begin
                    mem_req_wdata_o = w_wdata_lane;
                    mem_req_wstrb_o = w_strb_wide[7:0];
                end
            end
            S_DONE: begin
                wb_valid_o  = 1'b1;
                wb_rd_idx_o = r_rd_idx;
`ifdef YSYX_22040237_LSU_MISALIGN_EN
                if (r_misalign) begin
                    misalign_o = 1'b1;
                end else if (!r_store) begin
                    wb_wen_o  = 1'b1;
                    wb_data_o = w_ext;
                end
`else
                if (!r_store) begin
                    wb_wen_o  = 1'b1;
                    wb_data_o = w_ext;
                end
`endif
            end
            default: begin
            end
        endcase
    end

endmodule
